// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter: two-requester round-robin arbiter feeding a serial
// pattern detector. A granted word is shifted MSB first through a
// PAT_W-bit history; matches are flagged on det and counted, and the
// count is reported with a one-cycle done pulse at the end of the word.
module seq_det_arbiter #(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [WORD_W-1:0] data0,
  input  logic [WORD_W-1:0] data1,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              overlap,
  output logic              gnt0,
  output logic              gnt1,
  output logic              busy,
  output logic              bit_out,
  output logic              det,
  output logic              done,
  output logic              done_id,
  output logic [2:0]        match_cnt
);

  localparam int FCNT_W = $clog2(PAT_W + 1);
  localparam int BCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WORD_W - 1);
  localparam logic [FCNT_W-1:0] FCNT_FULL = FCNT_W'(PAT_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Arbitration and word context
  logic              ptr_reg;
  logic              id_reg;
  logic [WORD_W-1:0] word_reg;
  logic [PAT_W-1:0]  pattern_reg;
  logic              overlap_reg;
  logic [BCNT_W-1:0] bcnt_reg;
  logic [1:0]        gnt_reg;

  // Detector state
  logic [PAT_W-1:0]  hist_reg;
  logic [FCNT_W-1:0] fcnt_reg;
  logic [2:0]        mcnt_reg;
  logic              det_reg;
  logic [2:0]        match_cnt_reg;
  logic              done_id_reg;

  // Combinational helpers
  logic              start;
  logic              winner;
  logic [1:0]        lane_win;
  logic [PAT_W-1:0]  hist_shift;
  logic [FCNT_W-1:0] fcnt_inc;
  logic              fill_ok;
  logic              match;
  logic              last_bit;

  // A grant can only be issued from IDLE; with both requesting, the pointer decides.
  always_comb begin
    start  = 1'b0;
    winner = 1'b0;
    if (state_reg == IDLE) begin
      start = req0 | req1;
    end
    if (req0 && req1) begin
      winner = ptr_reg;
    end else begin
      winner = ~req0;
    end
  end

  // Per-requester grant decode
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign lane_win[gi] = start && (winner == 1'(gi));
    end
  endgenerate

  // Detector next values for the bit currently on bit_out
  always_comb begin
    hist_shift = {hist_reg[PAT_W-2:0], bit_out};
    if (fcnt_reg == FCNT_FULL) begin
      fcnt_inc = fcnt_reg;
    end else begin
      fcnt_inc = fcnt_reg + 1'b1;
    end
    fill_ok  = (int'(fcnt_reg) + 1) >= PAT_W;
    match    = (state_reg == SHIFT) && (hist_shift == pattern_reg) && fill_ok;
    last_bit = (bcnt_reg == BCNT_LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch context at grant, shift and detect during SHIFT
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg       <= 1'b0;
      id_reg        <= 1'b0;
      word_reg      <= '0;
      pattern_reg   <= '0;
      overlap_reg   <= 1'b0;
      bcnt_reg      <= '0;
      gnt_reg       <= '0;
      hist_reg      <= '0;
      fcnt_reg      <= '0;
      mcnt_reg      <= '0;
      det_reg       <= 1'b0;
      match_cnt_reg <= '0;
      done_id_reg   <= 1'b0;
    end else begin
      gnt_reg <= lane_win;
      det_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            ptr_reg       <= ~winner;
            id_reg        <= winner;
            word_reg      <= winner ? data1 : data0;
            pattern_reg   <= pattern;
            overlap_reg   <= overlap;
            bcnt_reg      <= '0;
            hist_reg      <= '0;
            fcnt_reg      <= '0;
            mcnt_reg      <= '0;
            match_cnt_reg <= '0;
          end
        end
        SHIFT: begin
          word_reg <= word_reg << 1;
          bcnt_reg <= bcnt_reg + 1'b1;
          hist_reg <= hist_shift;
          fcnt_reg <= (match && !overlap_reg) ? '0 : fcnt_inc;
          det_reg  <= match;
          mcnt_reg <= mcnt_reg + {2'b00, match};
          if (last_bit) begin
            match_cnt_reg <= mcnt_reg + {2'b00, match};
            done_id_reg   <= id_reg;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign gnt0      = gnt_reg[0];
  assign gnt1      = gnt_reg[1];
  assign busy      = (state_reg != IDLE);
  assign bit_out   = (state_reg == SHIFT) && word_reg[WORD_W-1];
  assign det       = det_reg;
  assign done      = (state_reg == REPORT);
  assign done_id   = done_id_reg;
  assign match_cnt = match_cnt_reg;

endmodule
